// File: rtl/writeback_cycle.sv
// Writeback stage: selects the result to retire, writes the 16x32 register file,
// serves two decode read ports with same-cycle bypass, and counts retired instructions.

module writeback_cycle_rd_port (
  input  logic [15:0][31:0] regs,
  input  logic              wb_en,
  input  logic [3:0]        wb_addr,
  input  logic [31:0]       wb_data,
  input  logic [3:0]        raddr,
  output logic [31:0]       rdata
);
  // Write-before-read: a read of the register being written sees the new value now.
  assign rdata = (wb_en && (raddr == wb_addr)) ? wb_data : regs[raddr];
endmodule

module writeback_cycle #(
  parameter logic [3:0] RA_INDEX = 4'd15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_RW,
  input  logic [31:0] alu_result_RW,
  input  logic [31:0] ldresult_RW,
  input  logic [31:0] instruction_RW,
  input  logic        isWb_RW,
  input  logic        isLd_RW,
  input  logic        isCall_RW,
  input  logic [3:0]  RD_RW,
  input  logic [3:0]  rs1_addr,
  input  logic [3:0]  rs2_addr,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic        wb_en,
  output logic [3:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic [31:0] retired_count
);
  localparam int NUM_RD = 2;

  logic [15:0][31:0]       regs;
  logic [NUM_RD-1:0][3:0]  raddr;
  logic [NUM_RD-1:0][31:0] rdata;

  assign wb_en   = isWb_RW & ~rst;
  assign wb_addr = isCall_RW ? RA_INDEX : RD_RW;

  // Load data wins over the call return address.
  always_comb begin
    wb_data = alu_result_RW;
    if (isLd_RW)        wb_data = ldresult_RW;
    else if (isCall_RW) wb_data = pc_RW + 32'd4;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        regs <= '0;
    else if (wb_en) regs[wb_addr] <= wb_data;
  end

  // Any non-bubble retires, whether or not it writes a register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         retired_count <= '0;
    else if (instruction_RW != '0)   retired_count <= retired_count + 32'd1;
  end

  assign raddr[0] = rs1_addr;
  assign raddr[1] = rs2_addr;

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    writeback_cycle_rd_port u_rd (
      .regs    (regs),
      .wb_en   (wb_en),
      .wb_addr (wb_addr),
      .wb_data (wb_data),
      .raddr   (raddr[g]),
      .rdata   (rdata[g])
    );
  end

  assign rd1 = rdata[0];
  assign rd2 = rdata[1];
endmodule

// File: tb/tb_writeback_cycle.sv
// Bench for writeback_cycle: directed vector table, reset/wrap sequences,
// then random traffic against an array-based register file model.

module tb_writeback_cycle;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_RW, alu_result_RW, ldresult_RW, instruction_RW;
  logic        isWb_RW, isLd_RW, isCall_RW;
  logic [3:0]  RD_RW, rs1_addr, rs2_addr;
  logic [31:0] rd1, rd2, wb_data, retired_count;
  logic        wb_en;
  logic [3:0]  wb_addr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  writeback_cycle dut (
    .clk(clk), .rst(rst), .pc_RW(pc_RW), .alu_result_RW(alu_result_RW),
    .ldresult_RW(ldresult_RW), .instruction_RW(instruction_RW),
    .isWb_RW(isWb_RW), .isLd_RW(isLd_RW), .isCall_RW(isCall_RW), .RD_RW(RD_RW),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd1(rd1), .rd2(rd2),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .retired_count(retired_count)
  );

  typedef struct {
    logic [31:0] pc, alu, ld, instr;
    logic        wb, isld, call;
    logic [3:0]  rd, rs1, rs2;
    logic        e_en;
    logic [3:0]  e_addr;
    logic [31:0] e_data, e_rd1, e_rd2, e_cnt;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, alu, ld, instr, input logic wb, isld, call,
                       input logic [3:0] rd, rs1, rs2);
    pc_RW = pc; alu_result_RW = alu; ldresult_RW = ld; instruction_RW = instr;
    isWb_RW = wb; isLd_RW = isld; isCall_RW = call; RD_RW = rd;
    rs1_addr = rs1; rs2_addr = rs2;
  endtask

  logic [31:0] mdl [16];
  logic [31:0] mcnt;

  initial begin
    // Expected values worked out by hand from a freshly reset register file.
    //           pc            alu          ld       instr  wb  ld  cl  rd  rs1 rs2  en  addr data          rd1           rd2           cnt
    vecs[0] = '{32'h10,       32'h1234,    32'h0,   32'd1, 1, 0, 0, 3,  3,  4,  1, 3,  32'h1234,     32'h1234,     32'h0,        32'd1};
    vecs[1] = '{32'h14,       32'h9,       32'h0,   32'd0, 0, 0, 0, 5,  3,  3,  0, 5,  32'h9,        32'h1234,     32'h1234,     32'd1};
    vecs[2] = '{32'h100,      32'h77,      32'hAA,  32'd2, 1, 1, 1, 2,  15, 2,  1, 15, 32'hAA,       32'hAA,       32'h0,        32'd2};
    vecs[3] = '{32'h100,      32'h77,      32'hAA,  32'd3, 1, 0, 1, 2,  15, 3,  1, 15, 32'h104,      32'h104,      32'h1234,     32'd3};
    vecs[4] = '{32'h200,      32'h55,      32'h0,   32'd4, 1, 0, 0, 7,  7,  7,  1, 7,  32'h55,       32'h55,       32'h55,       32'd4};
    vecs[5] = '{32'h204,      32'h99,      32'h0,   32'd5, 0, 0, 0, 7,  7,  15, 0, 7,  32'h99,       32'h55,       32'h104,      32'd5};
    vecs[6] = '{32'h208,      32'hDEAD,    32'h0,   32'd6, 1, 0, 0, 0,  0,  1,  1, 0,  32'hDEAD,     32'hDEAD,     32'h0,        32'd6};
    vecs[7] = '{32'hFFFFFFFC, 32'h1,       32'h0,   32'd7, 1, 0, 1, 4,  15, 0,  1, 15, 32'h0,        32'h0,        32'hDEAD,     32'd7};

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("por_cnt", retired_count, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(vecs[i].pc, vecs[i].alu, vecs[i].ld, vecs[i].instr, vecs[i].wb, vecs[i].isld,
            vecs[i].call, vecs[i].rd, vecs[i].rs1, vecs[i].rs2);
      #1;
      chk($sformatf("v%0d_wb_en", i),   {31'b0, wb_en}, {31'b0, vecs[i].e_en});
      chk($sformatf("v%0d_wb_addr", i), {28'b0, wb_addr}, {28'b0, vecs[i].e_addr});
      chk($sformatf("v%0d_wb_data", i), wb_data, vecs[i].e_data);
      chk($sformatf("v%0d_rd1", i),     rd1, vecs[i].e_rd1);
      chk($sformatf("v%0d_rd2", i),     rd2, vecs[i].e_rd2);
      @(posedge clk); #1;
      chk($sformatf("v%0d_cnt", i),     retired_count, vecs[i].e_cnt);
    end

    // r7 held 0 before the bypass write in v4; confirm it landed and r15 wrapped to 0.
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 7, 15);
    #1;
    chk("r7_after", rd1, 32'h55);
    chk("r15_after", rd2, 32'h0);

    // Reset asserted between edges with a write pending.
    drive(32'h0, 32'h5A5A, 0, 32'd1, 1, 0, 0, 9, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("rst_wb_en", {31'b0, wb_en}, 32'h0);
    chk("rst_cnt", retired_count, 32'h0);
    for (int a = 0; a < 16; a++) begin
      rs1_addr = 4'(a); rs2_addr = 4'(15 - a);
      #0.1;
      chk($sformatf("rst_rd1_%0d", a), rd1, 32'h0);
      chk($sformatf("rst_rd2_%0d", a), rd2, 32'h0);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 9, 9);
    #1;
    chk("rst_discard_r9", rd1, 32'h0);
    @(negedge clk);
    drive(32'h0, 32'h5A5A, 0, 32'd1, 1, 0, 0, 9, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 9, 9);
    #1;
    chk("post_rst_r9", rd1, 32'h5A5A);
    chk("post_rst_cnt", retired_count, 32'd1);

    // Counter wrap.
    force dut.retired_count = 32'hFFFFFFFF;
    #1 release dut.retired_count;
    #1 chk("wrap_pre", retired_count, 32'hFFFFFFFF);
    instruction_RW = 32'h13;
    @(posedge clk); #1;
    chk("wrap", retired_count, 32'h0);

    // Random traffic against the model, from a clean reset.
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 rst = 1'b0;
    for (int r = 0; r < 16; r++) mdl[r] = 32'h0;
    mcnt = 32'h0;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ed;
      logic [3:0]  ea;
      logic        ee;
      @(negedge clk);
      drive($urandom, $urandom, $urandom, ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom | 32'h1,
            1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            4'($urandom), 4'($urandom), 4'($urandom));
      if (n % 5 == 0) rs2_addr = RD_RW;
      ee = isWb_RW;
      ea = isCall_RW ? 4'd15 : RD_RW;
      ed = isLd_RW ? ldresult_RW : (isCall_RW ? pc_RW + 32'd4 : alu_result_RW);
      #1;
      chk("rnd_wb_en", {31'b0, wb_en}, {31'b0, ee});
      chk("rnd_wb_addr", {28'b0, wb_addr}, {28'b0, ea});
      chk("rnd_wb_data", wb_data, ed);
      chk("rnd_rd1", rd1, (ee && rs1_addr == ea) ? ed : mdl[rs1_addr]);
      chk("rnd_rd2", rd2, (ee && rs2_addr == ea) ? ed : mdl[rs2_addr]);
      @(posedge clk); #1;
      if (ee) mdl[ea] = ed;
      if (instruction_RW != 32'h0) mcnt = mcnt + 32'd1;
      chk("rnd_cnt", retired_count, mcnt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
